// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and the sync bundle carried by the delay line.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_PIPE_DELAY = 2;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Syncs are active-low, so the idle bundle is both syncs high and display disabled.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that lines up hs/vs/blank with the mappers' registered RGB.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic [$bits(sync_t)-1:0]   din,
  output logic [$bits(sync_t)-1:0]   dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, vga_clk, reset_n};
    assign dout = din;
  end else begin : g_pipe
    sync_t stage [DEPTH];

    // Reset flushes every stage so no stale sync pulse can leak out after release.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with registered coordinates and delayed sync/enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_out,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  hc_next;
  logic [9:0]  vc_next;
  logic [10:0] hc_wide;
  logic [10:0] vc_wide;
  sync_t       raw_next;
  sync_t       raw_q;
  sync_t       delayed;

  // Decode from the next-state counters so the registered outputs line up with DrawX/DrawY.
  always_comb begin
    hc_next = DrawX + 10'd1;
    vc_next = DrawY;
    if (DrawX == H_LAST) begin
      hc_next = '0;
      vc_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
    hc_wide        = {1'b0, hc_next};
    vc_wide        = {1'b0, vc_next};
    raw_next.hs    = !((hc_wide >= HS_START) && (hc_wide < HS_END));
    raw_next.vs    = !((vc_wide >= VS_START) && (vc_wide < VS_END));
    raw_next.blank = (hc_wide < H_VIS_END) && (vc_wide < V_VIS_END);
  end

  // Reset parks on the last pixel of the frame so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      raw_q       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      DrawX       <= hc_next;
      DrawY       <= vc_next;
      raw_q       <= raw_next;
      line_start  <= (hc_next == 10'd0);
      frame_start <= (hc_next == 10'd0) && (vc_next == 10'd0);
    end
  end

  assign blank = raw_q.blank;

  sync_delay_line #(
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .din    (raw_q),
    .dout   (delayed)
  );

  assign hs        = delayed.hs;
  assign vs        = delayed.vs;
  assign blank_out = delayed.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default build, a PIPE_DELAY=0 build and a shrunken-raster build side by side.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HV = 16, S_HFP = 2, S_HSY = 4, S_HBP = 3;
  localparam int S_VV = 12, S_VFP = 2, S_VSY = 2, S_VBP = 3, S_D = 3;
  localparam int S_HT = S_HV + S_HFP + S_HSY + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VSY + S_VBP;
  localparam int S_FRAME = S_HT * S_VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       blank_out;
    logic       line_start;
    logic       frame_start;
  } out_t;

  typedef struct {
    out_t e2;
    out_t e0;
    out_t es;
  } exp_t;

  exp_t sb[$];

  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] x2, y2, x0, y0, xs, ys;
  logic blank2, hs2, vs2, bo2, ls2, fs2;
  logic blank0, hs0, vs0, bo0, ls0, fs0;
  logic blanks, hss, vss, bos, lss, fss;
  out_t o2, o0, os;

  assign o2 = {x2, y2, blank2, hs2, vs2, bo2, ls2, fs2};
  assign o0 = {x0, y0, blank0, hs0, vs0, bo0, ls0, fs0};
  assign os = {xs, ys, blanks, hss, vss, bos, lss, fss};

  int pos = -1;
  int n_checks = 0;
  int n_pass = 0;

  vga_timing_gen dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x2), .DrawY(y2), .blank(blank2),
    .hs(hs2), .vs(vs2), .blank_out(bo2), .line_start(ls2), .frame_start(fs2)
  );

  vga_timing_gen #(.PIPE_DELAY(0)) dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0), .blank(blank0),
    .hs(hs0), .vs(vs0), .blank_out(bo0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP), .PIPE_DELAY(S_D)
  ) duts (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(xs), .DrawY(ys), .blank(blanks),
    .hs(hss), .vs(vss), .blank_out(bos), .line_start(lss), .frame_start(fss)
  );

  // Reference raster: p is the number of edges since release (p<0 means in reset).
  function automatic out_t model(int hv, int hfp, int hsy, int hbp, int vv, int vfp,
                                 int vsy, int vbp, int d, int p);
    int ht, vt, x, y, q, xq, yq;
    out_t o;
    ht = hv + hfp + hsy + hbp;
    vt = vv + vfp + vsy + vbp;
    if (p < 0) begin
      o = {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      return o;
    end
    x = p % ht;
    y = (p / ht) % vt;
    o.x = 10'(x);
    o.y = 10'(y);
    o.blank = (x < hv) && (y < vv);
    o.line_start = (x == 0);
    o.frame_start = (x == 0) && (y == 0);
    q = p - d;
    if (q < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.blank_out = 1'b0;
    end else begin
      xq = q % ht;
      yq = (q / ht) % vt;
      o.hs = !((xq >= hv + hfp) && (xq < hv + hfp + hsy));
      o.vs = !((yq >= vv + vfp) && (yq < vv + vfp + vsy));
      o.blank_out = (xq < hv) && (yq < vv);
    end
    return o;
  endfunction

  function automatic exp_t expect_at(int p);
    exp_t e;
    e.e2 = model(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                 DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, 2, p);
    e.e0 = model(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                 DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, 0, p);
    e.es = model(S_HV, S_HFP, S_HSY, S_HBP, S_VV, S_VFP, S_VSY, S_VBP, S_D, p);
    return e;
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    pos++;
    sb.push_back(expect_at(pos));
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int rise_pos = -1;
    #1 reset_n = 1'b0;
    #2;
    sb.push_back(expect_at(-1));
    e = sb.pop_front();
    if (o2 !== e.e2) $display("[TB] FAIL reset_async_d2 got %h want %h", o2, e.e2); else n_pass++;
    n_checks++;
    if (os !== e.es) $display("[TB] FAIL reset_async_small got %h want %h", os, e.es); else n_pass++;
    n_checks++;
    repeat (2) @(posedge vga_clk);
    #1;
    sb.push_back(expect_at(-1));
    e = sb.pop_front();
    if (o2 !== e.e2) $display("[TB] FAIL reset_held_d2 got %h want %h", o2, e.e2); else n_pass++;
    n_checks++;
    if (o0 !== e.e0) $display("[TB] FAIL reset_held_d0 got %h want %h", o0, e.e0); else n_pass++;
    n_checks++;
    @(negedge vga_clk);
    reset_n = 1'b1;
    pos = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      if (o2 !== e.e2) $display("[TB] FAIL release_d2 p=%0d got %h want %h", pos, o2, e.e2); else n_pass++;
      n_checks++;
      if (o0 !== e.e0) $display("[TB] FAIL release_d0 p=%0d got %h want %h", pos, o0, e.e0); else n_pass++;
      n_checks++;
      if (os !== e.es) $display("[TB] FAIL release_small p=%0d got %h want %h", pos, os, e.es); else n_pass++;
      n_checks++;
      if (bo2 === 1'b1 && rise_pos < 0) rise_pos = pos;
    end
    if (rise_pos !== 2) $display("[TB] FAIL blank_out_rise got edge %0d want edge 2", rise_pos); else n_pass++;
    n_checks++;
  endtask

  task automatic test_line_scan();
    exp_t e;
    int ls_cnt = 0, first_ls = -1, second_ls = -1, hs_low = 0, fall_off = -1, last_low_off = -1;
    logic prev_hs;
    prev_hs = hs2;
    for (int i = 0; i < 1600; i++) begin
      tick();
      e = sb.pop_front();
      if (o2 !== e.e2) $display("[TB] FAIL line_d2 p=%0d got %h want %h", pos, o2, e.e2); else n_pass++;
      n_checks++;
      if (o0 !== e.e0) $display("[TB] FAIL line_d0 p=%0d got %h want %h", pos, o0, e.e0); else n_pass++;
      n_checks++;
      if (os !== e.es) $display("[TB] FAIL line_small p=%0d got %h want %h", pos, os, e.es); else n_pass++;
      n_checks++;
      if (ls2 === 1'b1) begin
        ls_cnt++;
        if (first_ls < 0) first_ls = pos;
        else if (second_ls < 0) second_ls = pos;
      end
      if (first_ls >= 0 && pos < first_ls + 800 && hs2 === 1'b0) begin
        hs_low++;
        last_low_off = pos - first_ls;
      end
      if (first_ls >= 0 && prev_hs === 1'b1 && hs2 === 1'b0 && fall_off < 0) fall_off = pos - first_ls;
      prev_hs = hs2;
    end
    if (ls_cnt !== 2) $display("[TB] FAIL line_start_count got %0d want 2", ls_cnt); else n_pass++;
    n_checks++;
    if (second_ls - first_ls !== 800) $display("[TB] FAIL line_period got %0d want 800", second_ls - first_ls); else n_pass++;
    n_checks++;
    if (hs_low !== 96) $display("[TB] FAIL hs_width got %0d want 96", hs_low); else n_pass++;
    n_checks++;
    if (fall_off !== 658) $display("[TB] FAIL hs_fall_offset got %0d want 658", fall_off); else n_pass++;
    n_checks++;
    if (last_low_off !== 753) $display("[TB] FAIL hs_last_low_offset got %0d want 753", last_low_off); else n_pass++;
    n_checks++;
  endtask

  task automatic test_frame_scan();
    exp_t e;
    int fs_cnt = 0, first_fs = -1, second_fs = -1, vs_low = 0;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      tick();
      e = sb.pop_front();
      if (os !== e.es) $display("[TB] FAIL frame_small p=%0d got %h want %h", pos, os, e.es); else n_pass++;
      n_checks++;
      if (o2 !== e.e2) $display("[TB] FAIL frame_d2 p=%0d got %h want %h", pos, o2, e.e2); else n_pass++;
      n_checks++;
      if (fss === 1'b1) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = pos;
        else if (second_fs < 0) second_fs = pos;
      end
      if (first_fs >= 0 && pos < first_fs + S_FRAME && vss === 1'b0) vs_low++;
    end
    if (fs_cnt !== 2) $display("[TB] FAIL frame_start_count got %0d want 2", fs_cnt); else n_pass++;
    n_checks++;
    if (second_fs - first_fs !== S_FRAME) $display("[TB] FAIL frame_period got %0d want %0d", second_fs - first_fs, S_FRAME); else n_pass++;
    n_checks++;
    if (vs_low !== S_VSY * S_HT) $display("[TB] FAIL vs_width got %0d want %0d", vs_low, S_VSY * S_HT); else n_pass++;
    n_checks++;
  endtask

  task automatic test_wrap();
    exp_t e;
    int guard = 0;
    while ((pos % S_FRAME) != (5 * S_HT + S_HT - 1) && guard < 2 * S_FRAME) begin
      tick();
      e = sb.pop_front();
      guard++;
    end
    if (xs !== 10'(S_HT - 1) || ys !== 10'd5) $display("[TB] FAIL wrap_line_pre got (%0d,%0d) want (%0d,5)", xs, ys, S_HT - 1); else n_pass++;
    n_checks++;
    tick();
    e = sb.pop_front();
    if (xs !== 10'd0 || ys !== 10'd6 || fss !== 1'b0 || lss !== 1'b1)
      $display("[TB] FAIL wrap_line got (%0d,%0d) fs=%b ls=%b want (0,6) fs=0 ls=1", xs, ys, fss, lss);
    else n_pass++;
    n_checks++;
    guard = 0;
    while ((pos % S_FRAME) != (S_FRAME - 1) && guard < 2 * S_FRAME) begin
      tick();
      e = sb.pop_front();
      guard++;
    end
    if (xs !== 10'(S_HT - 1) || ys !== 10'(S_VT - 1)) $display("[TB] FAIL wrap_frame_pre got (%0d,%0d) want (%0d,%0d)", xs, ys, S_HT - 1, S_VT - 1); else n_pass++;
    n_checks++;
    tick();
    e = sb.pop_front();
    if (xs !== 10'd0 || ys !== 10'd0 || fss !== 1'b1 || blanks !== 1'b1)
      $display("[TB] FAIL wrap_frame got (%0d,%0d) fs=%b blank=%b want (0,0) fs=1 blank=1", xs, ys, fss, blanks);
    else n_pass++;
    n_checks++;
    if (os !== e.es) $display("[TB] FAIL wrap_frame_vec got %h want %h", os, e.es); else n_pass++;
    n_checks++;
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    int guard = 0;
    while ((pos % DEF_H_TOTAL) != 700 && guard < 2 * DEF_H_TOTAL) begin
      tick();
      e = sb.pop_front();
      guard++;
    end
    if (hs2 !== 1'b0) $display("[TB] FAIL midreset_hs_before got %b want 0", hs2); else n_pass++;
    n_checks++;
    reset_n = 1'b0;
    #1;
    sb.push_back(expect_at(-1));
    e = sb.pop_front();
    if (hs2 !== 1'b1 || bo2 !== 1'b0) $display("[TB] FAIL midreset_async hs=%b blank_out=%b want hs=1 blank_out=0", hs2, bo2); else n_pass++;
    n_checks++;
    if (o2 !== e.e2) $display("[TB] FAIL midreset_d2 got %h want %h", o2, e.e2); else n_pass++;
    n_checks++;
    if (os !== e.es) $display("[TB] FAIL midreset_small got %h want %h", os, e.es); else n_pass++;
    n_checks++;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    pos = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = sb.pop_front();
      if (o2 !== e.e2) $display("[TB] FAIL restart_d2 p=%0d got %h want %h", pos, o2, e.e2); else n_pass++;
      n_checks++;
      if (os !== e.es) $display("[TB] FAIL restart_small p=%0d got %h want %h", pos, os, e.es); else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_pipe_delay_zero();
    exp_t e;
    int x, y, hs_low = 0;
    logic exp_hs, exp_bo;
    for (int i = 0; i < DEF_H_TOTAL; i++) begin
      tick();
      e = sb.pop_front();
      x = pos % 800;
      y = (pos / 800) % 525;
      exp_hs = !(x >= 656 && x <= 751);
      exp_bo = (x < 640) && (y < 480);
      if (hs0 !== exp_hs || bo0 !== exp_bo)
        $display("[TB] FAIL pd0_sync x=%0d hs=%b blank_out=%b want hs=%b blank_out=%b", x, hs0, bo0, exp_hs, exp_bo);
      else n_pass++;
      n_checks++;
      if (o0 !== e.e0) $display("[TB] FAIL pd0_vec p=%0d got %h want %h", pos, o0, e.e0); else n_pass++;
      n_checks++;
      if (hs0 === 1'b0) hs_low++;
    end
    if (hs_low !== 96) $display("[TB] FAIL pd0_hs_width got %0d want 96", hs_low); else n_pass++;
    n_checks++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    assert (DEF_H_TOTAL <= 1024 && DEF_V_TOTAL <= 1024) else $error("[TB] default totals exceed 10-bit counters");
    assert (S_HT <= 1024 && S_VT <= 1024) else $error("[TB] small totals exceed 10-bit counters");
    test_reset();
    test_line_scan();
    test_frame_scan();
    test_wrap();
    test_mid_frame_reset();
    test_pipe_delay_zero();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
